// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//
// Elastic handshake pipeline stage. Each word accepted from upstream is
// transformed (pass-through, +INCR or -INCR) and kept, together with its
// carry/borrow bit, in DEPTH words of storage: one output register plus a
// (DEPTH-1)-entry circular FIFO behind it. Downstream sees the oldest word in
// the output register, so a slow consumer does not stall upstream until the
// storage is full.
//
// Ports
//   clk            clock, all logic on the rising edge
//   reset          synchronous, active-high reset
//   DIR            upstream presents a valid word on data_in
//   data_in        upstream word
//   ack_prev       one-cycle pulse: the word on data_in has been captured
//   DOR            data_out/carry_out hold a valid word
//   data_out       transformed word (0 while DOR=0)
//   carry_out      carry (MODE 1) / borrow (MODE 2) of data_out, 0 in MODE 0
//   ack_from_next  downstream consumed the word on data_out
//   level          number of stored words, 0..DEPTH
//   full           level == DEPTH (registered)
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
  parameter int              WIDTH = 8,
  parameter int              DEPTH = 2,
  parameter int              MODE  = 1,
  parameter logic [WIDTH-1:0] INCR = WIDTH'(1),
  parameter int              LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DIR,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack_prev,
  output logic             DOR,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  input  logic             ack_from_next,
  output logic [LW-1:0]    level,
  output logic             full
);

  // The FIFO behind the output register holds DEPTH-1 words. With DEPTH=1
  // it is never written (capture in HOLD requires !full), but a one-entry
  // array keeps the declarations legal. The array is sized to a power of two
  // so the pointer width always matches the index range.
  localparam int FDEPTH = (DEPTH > 1) ? DEPTH - 1 : 1;
  localparam int PW     = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int FSIZE  = 1 << PW;

  typedef enum logic {IN_IDLE, IN_ACK}    in_state_t;
  typedef enum logic {OUT_EMPTY, OUT_HOLD} out_state_t;

  in_state_t        r_in_state;
  out_state_t       r_out_state;
  logic             r_ack_prev;
  logic             r_dor;
  logic [WIDTH-1:0] r_data_out;
  logic             r_carry_out;
  logic [LW-1:0]    r_level;
  logic             r_full;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;

  // Each entry stores {carry, word}.
  logic [WIDTH:0]   r_mem [FSIZE];

  logic [WIDTH-1:0] w_word;
  logic             w_carry;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_capture;
  logic             w_consume;
  logic             w_fifo_has;
  logic             w_fifo_wr;
  logic             w_fifo_rd;
  logic [LW-1:0]    w_level_next;

  // ---------------------------------------------------------------------------
  // Transform. The extra top bit of the (WIDTH+1)-bit sum/difference is the
  // carry or, for unsigned subtraction, the borrow.
  // ---------------------------------------------------------------------------
  assign w_sum  = {1'b0, data_in} + {1'b0, INCR};
  assign w_diff = {1'b0, data_in} - {1'b0, INCR};

  generate
    if (MODE == 1) begin : g_add
      assign {w_carry, w_word} = w_sum;
    end else if (MODE == 2) begin : g_sub
      assign {w_carry, w_word} = w_diff;
    end else begin : g_pass
      assign w_word  = data_in;
      assign w_carry = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshake decisions for this edge. full is the registered flag, so a
  // consume on the same edge does not open a slot for a capture.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_capture  = (r_in_state == IN_IDLE) && DIR && !r_full;
    w_consume  = (r_out_state == OUT_HOLD) && ack_from_next;
    // In HOLD the output register accounts for one word; anything beyond
    // that lives in the FIFO.
    w_fifo_has = (r_level > LW'(1));
    // A captured word bypasses the FIFO only when the output register is
    // free: either EMPTY, or being consumed with nothing queued ahead.
    w_fifo_wr  = w_capture && (r_out_state == OUT_HOLD) && (!w_consume || w_fifo_has);
    w_fifo_rd  = w_consume && w_fifo_has;

    w_level_next = r_level;
    if (w_capture && !w_consume) begin
      w_level_next = r_level + LW'(1);
    end else if (!w_capture && w_consume) begin
      w_level_next = r_level - LW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage, no reset so it maps onto plain RAM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset && w_fifo_wr) begin
      r_mem[r_wr_ptr] <= {w_carry, w_word};
    end
  end

  // ---------------------------------------------------------------------------
  // Input FSM, output FSM, level and pointers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_state  <= IN_IDLE;
      r_out_state <= OUT_EMPTY;
      r_ack_prev  <= 1'b0;
      r_dor       <= 1'b0;
      r_data_out  <= '0;
      r_carry_out <= 1'b0;
      r_level     <= '0;
      r_full      <= 1'b0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else begin
      // Input side: after an ack, skip one cycle because upstream still
      // presents the word just taken.
      case (r_in_state)
        IN_IDLE: begin
          if (w_capture) begin
            r_ack_prev <= 1'b1;
            r_in_state <= IN_ACK;
          end else begin
            r_ack_prev <= 1'b0;
          end
        end
        IN_ACK: begin
          r_ack_prev <= 1'b0;
          r_in_state <= IN_IDLE;
        end
        default: begin
          r_ack_prev <= 1'b0;
          r_in_state <= IN_IDLE;
        end
      endcase

      // Output side.
      case (r_out_state)
        OUT_EMPTY: begin
          if (w_capture) begin
            r_data_out  <= w_word;
            r_carry_out <= w_carry;
            r_dor       <= 1'b1;
            r_out_state <= OUT_HOLD;
          end
        end
        OUT_HOLD: begin
          if (w_consume) begin
            if (w_fifo_has) begin
              {r_carry_out, r_data_out} <= r_mem[r_rd_ptr];
            end else if (w_capture) begin
              r_data_out  <= w_word;
              r_carry_out <= w_carry;
            end else begin
              r_data_out  <= '0;
              r_carry_out <= 1'b0;
              r_dor       <= 1'b0;
              r_out_state <= OUT_EMPTY;
            end
          end
        end
        default: begin
          r_out_state <= OUT_EMPTY;
          r_dor       <= 1'b0;
        end
      endcase

      if (w_fifo_wr) begin
        r_wr_ptr <= (r_wr_ptr == PW'(FDEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_fifo_rd) begin
        r_rd_ptr <= (r_rd_ptr == PW'(FDEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      end

      r_level <= w_level_next;
      r_full  <= (w_level_next == LW'(DEPTH));
    end
  end

  assign ack_prev  = r_ack_prev;
  assign DOR       = r_dor;
  assign data_out  = r_data_out;
  assign carry_out = r_carry_out;
  assign level     = r_level;
  assign full      = r_full;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Three instances share one stimulus stream:
//   inst 0: DEPTH=2, MODE=1 (+1)
//   inst 1: DEPTH=4, MODE=1 (+1)
//   inst 2: DEPTH=1, MODE=2 (-1)
// The reference model keeps each instance's stored words as an ordered list
// and applies the handshake rules directly. A negedge process compares every
// output of every instance against it each cycle; directed sequences add
// literal expectations, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       dir;
  logic [7:0] din;
  logic       ack_next;

  logic [2:0]      ack_p;
  logic [2:0]      dor;
  logic [2:0][7:0] dout;
  logic [2:0]      cy;
  logic [2:0]      fl;
  logic [1:0]      lvl_a;
  logic [2:0]      lvl_b;
  logic [0:0]      lvl_c;
  logic [2:0][2:0] lvl;

  assign lvl[0] = {1'b0, lvl_a};
  assign lvl[1] = lvl_b;
  assign lvl[2] = {2'b00, lvl_c};

  pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .MODE(1), .INCR(8'd1)) u_a (
    .clk(clk), .reset(reset), .DIR(dir), .data_in(din), .ack_prev(ack_p[0]),
    .DOR(dor[0]), .data_out(dout[0]), .carry_out(cy[0]),
    .ack_from_next(ack_next), .level(lvl_a), .full(fl[0]));

  pipe_stage_buf #(.WIDTH(8), .DEPTH(4), .MODE(1), .INCR(8'd1)) u_b (
    .clk(clk), .reset(reset), .DIR(dir), .data_in(din), .ack_prev(ack_p[1]),
    .DOR(dor[1]), .data_out(dout[1]), .carry_out(cy[1]),
    .ack_from_next(ack_next), .level(lvl_b), .full(fl[1]));

  pipe_stage_buf #(.WIDTH(8), .DEPTH(1), .MODE(2), .INCR(8'd1)) u_c (
    .clk(clk), .reset(reset), .DIR(dir), .data_in(din), .ack_prev(ack_p[2]),
    .DOR(dor[2]), .data_out(dout[2]), .carry_out(cy[2]),
    .ack_from_next(ack_next), .level(lvl_c), .full(fl[2]));

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d t=%0t got=%0d want=%0d", nm, inst, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int depth_m [3] = '{2, 4, 1};
  int mode_m  [3] = '{1, 1, 2};
  int mword   [3][4];
  int mcy     [3][4];
  int mcnt    [3] = '{0, 0, 0};
  int mack    [3] = '{0, 0, 0};
  bit chk_en = 1'b0;

  function automatic int xword(input int mode, input int d);
    if (mode == 1) return (d + 1) % 256;
    if (mode == 2) return (d - 1 + 256) % 256;
    return d;
  endfunction

  function automatic int xcarry(input int mode, input int d);
    if (mode == 1) return (d + 1 > 255) ? 1 : 0;
    if (mode == 2) return (d - 1 < 0) ? 1 : 0;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        mcnt[i] = 0;
        mack[i] = 0;
      end
      chk_en = 1'b1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit cap;
        bit cons;
        cap  = (mack[i] == 0) && dir && (mcnt[i] < depth_m[i]);
        cons = ack_next && (mcnt[i] > 0);
        if (cons) begin
          for (int k = 0; k < 3; k++) begin
            mword[i][k] = mword[i][k+1];
            mcy[i][k]   = mcy[i][k+1];
          end
          mcnt[i]--;
        end
        if (cap) begin
          mword[i][mcnt[i]] = xword(mode_m[i], int'(din));
          mcy[i][mcnt[i]]   = xcarry(mode_m[i], int'(din));
          mcnt[i]++;
        end
        mack[i] = cap ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check("ack_prev",  i, 32'(ack_p[i]),   32'(mack[i]));
        check("DOR",       i, 32'(dor[i]),     (mcnt[i] > 0) ? 32'd1 : 32'd0);
        check("data_out",  i, 32'(dout[i]),    (mcnt[i] > 0) ? 32'(mword[i][0]) : 32'd0);
        check("carry_out", i, 32'(cy[i]),      (mcnt[i] > 0) ? 32'(mcy[i][0]) : 32'd0);
        check("level",     i, 32'(lvl[i]),     32'(mcnt[i]));
        check("full",      i, 32'(fl[i]),      (mcnt[i] == depth_m[i]) ? 32'd1 : 32'd0);
      end
    end
  end

  // Advance one clock; inputs change and literal checks sample 2 time units
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1; dir = 1'b0; din = 8'd0; ack_next = 1'b0;
    step(); step();
    check("rst_dor",   0, 32'(dor[0]),  0);
    check("rst_level", 0, 32'(lvl[0]),  0);
    check("rst_full",  0, 32'(fl[0]),   0);
    check("rst_ack",   0, 32'(ack_p[0]), 0);
    check("rst_data",  0, 32'(dout[0]), 0);

    // Single word: capture and output on the same edge.
    reset = 1'b0; dir = 1'b1; din = 8'd5;
    step();
    check("single_ack",   0, 32'(ack_p[0]), 1);
    check("single_dor",   0, 32'(dor[0]),   1);
    check("single_data",  0, 32'(dout[0]),  6);
    check("single_carry", 0, 32'(cy[0]),    0);
    check("single_level", 0, 32'(lvl[0]),  1);
    check("single_sub",   2, 32'(dout[2]),  4);
    dir = 1'b0;
    step();
    check("single_ack_low", 0, 32'(ack_p[0]), 0);
    ack_next = 1'b1;
    step();
    check("drain_dor",   0, 32'(dor[0]),  0);
    check("drain_data",  0, 32'(dout[0]), 0);
    check("drain_level", 0, 32'(lvl[0]),  0);
    ack_next = 1'b0;

    // Wrap / carry / borrow.
    dir = 1'b1; din = 8'd255;
    step();
    check("wrap_add_data",  0, 32'(dout[0]), 0);
    check("wrap_add_carry", 0, 32'(cy[0]),   1);
    check("sub_255_data",   2, 32'(dout[2]), 254);
    check("sub_255_borrow", 2, 32'(cy[2]),   0);
    dir = 1'b0; ack_next = 1'b1;
    step();
    ack_next = 1'b0; dir = 1'b1; din = 8'd0;
    step();
    check("wrap_sub_data",   2, 32'(dout[2]), 255);
    check("wrap_sub_borrow", 2, 32'(cy[2]),   1);
    check("add_0_data",      0, 32'(dout[0]), 1);
    dir = 1'b0; ack_next = 1'b1;
    step();
    ack_next = 1'b0;

    // Backpressure on the DEPTH=2 instance.
    dir = 1'b1; din = 8'd10;
    step();
    din = 8'd11;
    step();
    step();
    check("bp_level", 0, 32'(lvl[0]),   2);
    check("bp_full",  0, 32'(fl[0]),    1);
    check("bp_ack11", 0, 32'(ack_p[0]), 1);
    din = 8'd12;
    step();
    step();
    check("bp_noack",  0, 32'(ack_p[0]), 0);
    check("bp_level2", 0, 32'(lvl[0]),   2);
    check("bp_head",   0, 32'(dout[0]),  11);
    ack_next = 1'b1;
    step();
    check("bp_next",    0, 32'(dout[0]),  12);
    check("bp_level1",  0, 32'(lvl[0]),   1);
    check("bp_notfull", 0, 32'(fl[0]),    0);
    check("bp_noack2",  0, 32'(ack_p[0]), 0);
    ack_next = 1'b0;
    step();
    check("bp_cap12", 0, 32'(ack_p[0]), 1);
    check("bp_lvl12", 0, 32'(lvl[0]),   2);
    dir = 1'b0; ack_next = 1'b1;
    repeat (5) step();
    ack_next = 1'b0;
    check("bp_empty_a", 0, 32'(lvl[0]), 0);
    check("bp_empty_b", 1, 32'(lvl[1]), 0);

    // Ordering on the DEPTH=4 instance, repeated to wrap the FIFO pointers.
    for (int r = 0; r < 3; r++) begin
      for (int v = 1; v <= 4; v++) begin
        dir = 1'b1; din = 8'(v);
        step();
        dir = 1'b0;
        step();
      end
      check("ord_full",  1, 32'(fl[1]),   1);
      check("ord_level", 1, 32'(lvl[1]),  4);
      check("ord_head",  1, 32'(dout[1]), 2);
      for (int k = 0; k < 4; k++) begin
        ack_next = 1'b1;
        step();
        ack_next = 1'b0;
        if (k < 3) begin
          check("ord_word", 1, 32'(dout[1]), 32'(k + 3));
        end else begin
          check("ord_dor_end", 1, 32'(dor[1]), 0);
          check("ord_lvl_end", 1, 32'(lvl[1]), 0);
        end
        step();
      end
    end

    // Simultaneous capture and consume at level 1.
    dir = 1'b1; din = 8'd20;
    step();
    din = 8'd30;
    step();
    ack_next = 1'b1;
    step();
    check("sim_level", 0, 32'(lvl[0]),   1);
    check("sim_dor",   0, 32'(dor[0]),   1);
    check("sim_data",  0, 32'(dout[0]),  31);
    check("sim_ack",   0, 32'(ack_p[0]), 1);
    ack_next = 1'b0; dir = 1'b0;
    step();
    ack_next = 1'b1;
    step();
    ack_next = 1'b0;

    // Reset mid-operation, DIR kept high across it.
    dir = 1'b1; din = 8'd40;
    step();
    dir = 1'b0;
    step();
    dir = 1'b1; din = 8'd41;
    step();
    check("mid_level", 0, 32'(lvl[0]), 2);
    check("mid_dor",   0, 32'(dor[0]), 1);
    reset = 1'b1; din = 8'd50;
    step();
    check("mrst_dor",   0, 32'(dor[0]),   0);
    check("mrst_level", 0, 32'(lvl[0]),   0);
    check("mrst_ack",   0, 32'(ack_p[0]), 0);
    check("mrst_data",  0, 32'(dout[0]),  0);
    check("mrst_full",  0, 32'(fl[0]),    0);
    reset = 1'b0;
    step();
    check("post_ack",   0, 32'(ack_p[0]), 1);
    check("post_level", 0, 32'(lvl[0]),   1);
    check("post_data",  0, 32'(dout[0]),  51);
    dir = 1'b0;
    step();
    check("post_ack_low", 0, 32'(ack_p[0]), 0);
    check("post_level2",  0, 32'(lvl[0]),   1);
    ack_next = 1'b1;
    step();
    ack_next = 1'b0;

    // Randomized traffic, checked every cycle by the model comparison.
    for (int n = 0; n < 3000; n++) begin
      dir      = ($urandom_range(0, 99) < 60);
      din      = 8'($urandom);
      ack_next = ($urandom_range(0, 99) < 50);
      reset    = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; dir = 1'b0; ack_next = 1'b1;
    repeat (6) step();
    ack_next = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
